// File: rtl/eka_icache_if.sv
// Word-wide instruction memory read bus between eka_icache (master) and instruction memory (slave).
interface eka_icache_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ack;
  logic [31:0]           mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/eka_icache.sv
// eka_icache: direct-mapped read-only instruction cache, 4-word lines, combinational hit path.
// Define EKA_ICACHE_PERF_EN to add the hit_count / miss_count performance counters.
module eka_icache #(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_LINES  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  input  logic                  flush,
  output logic [31:0]           instruction,
  output logic                  inst_valid,
`ifdef EKA_ICACHE_PERF_EN
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count,
`endif
  eka_icache_if.master          mem
);
  localparam int IW = $clog2(NUM_LINES);
  localparam int TW = ADDR_WIDTH - 4 - IW;
  localparam int LW = ADDR_WIDTH - 4;

  localparam logic [0:0]  IDLE   = 1'b0;
  localparam logic [0:0]  REFILL = 1'b1;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic [0:0]           state;
  logic [NUM_LINES-1:0] valid;
  logic [TW-1:0]        tag_arr  [NUM_LINES];
  logic [31:0]          data_arr [NUM_LINES][4];
  logic [LW-1:0]        refill_line;
  logic [1:0]           word_cnt;
  logic                 discard;

  logic [1:0]    offset;
  logic [IW-1:0] index;
  logic [TW-1:0] tag;
  logic [IW-1:0] refill_index;
  logic [TW-1:0] refill_tag;
  logic          hit;
  logic          ack_in;
  logic          last_ack;
  logic          start_refill;
  logic [1:0]    unused_byte_bits;

  assign offset           = inst_addr[3:2];
  assign index            = inst_addr[4+IW-1:4];
  assign tag              = inst_addr[ADDR_WIDTH-1:4+IW];
  assign unused_byte_bits = inst_addr[1:0];

  // The line base is kept without its four zero offset bits; index sits in the low bits.
  assign refill_index = refill_line[IW-1:0];
  assign refill_tag   = refill_line[LW-1:IW];

  assign hit         = (state == IDLE) && valid[index] && (tag_arr[index] == tag);
  assign inst_valid  = hit;
  assign instruction = hit ? data_arr[index][offset] : NOP;

  assign ack_in       = (state == REFILL) && mem.mem_ack;
  assign last_ack     = ack_in && (word_cnt == 2'd3);
  assign start_refill = (state == IDLE) && !hit && !flush;

  assign mem.mem_req  = (state == REFILL);
  assign mem.mem_addr = (state == REFILL) ? {refill_line, word_cnt, 2'b00} : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      word_cnt    <= 2'd0;
      discard     <= 1'b0;
      refill_line <= '0;
    end else if (state == IDLE) begin
      if (start_refill) begin
        refill_line <= {tag, index};
        word_cnt    <= 2'd0;
        state       <= REFILL;
      end
    end else begin
      if (ack_in) begin
        word_cnt <= word_cnt + 2'd1;
      end
      // A flush mid-refill lets the bus burst finish but keeps the line from being validated.
      if (last_ack) begin
        state   <= IDLE;
        discard <= 1'b0;
      end else if (flush) begin
        discard <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
    end else if (flush) begin
      valid <= '0;
    end else if (last_ack && !discard) begin
      valid[refill_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (ack_in) begin
      data_arr[refill_index][word_cnt] <= mem.mem_rdata;
    end
    if (last_ack) begin
      tag_arr[refill_index] <= refill_tag;
    end
  end

`ifdef EKA_ICACHE_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
    end else begin
      if (hit) begin
        hit_count <= hit_count + 32'd1;
      end
      if (start_refill) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_eka_icache.sv
// Randomized scoreboard bench for eka_icache: a reference cache model predicts hits, bus traffic and
// fetched words; a monitor process checks the DUT outputs against the queued expectations.
`timescale 1ns/1ps
module tb_eka_icache;
  localparam int AW = 32;
  localparam int NL = 16;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] inst_addr = '0;
  logic          flush = 1'b0;
  logic [31:0]   instruction;
  logic          inst_valid;
`ifdef EKA_ICACHE_PERF_EN
  logic [31:0]   hit_count;
  logic [31:0]   miss_count;
`endif

  eka_icache_if #(.ADDR_WIDTH(AW)) bus ();

  eka_icache #(.ADDR_WIDTH(AW), .NUM_LINES(NL)) dut (
    .clk         (clk),
    .reset       (reset),
    .inst_addr   (inst_addr),
    .flush       (flush),
    .instruction (instruction),
    .inst_valid  (inst_valid),
`ifdef EKA_ICACHE_PERF_EN
    .hit_count   (hit_count),
    .miss_count  (miss_count),
`endif
    .mem         (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          wait_states = 0;
  bit          stray_en = 1'b0;
  bit          model_valid [NL];
  logic [31:0] model_tag [NL];
  int          model_hits = 0;
  int          model_misses = 0;
  logic [31:0] exp_inst [$];
  logic [31:0] exp_bus [$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0050_0093;
      32'h4:   return 32'h0010_0113;
      32'h8:   return 32'h0020_81B3;
      32'hC:   return 32'h0000_006F;
      default: return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic bit model_hit(input logic [31:0] a);
    int idx;
    idx = int'((a / 16) % NL);
    return model_valid[idx] && (model_tag[idx] == a / (16 * NL));
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NL; i++) model_valid[i] = 1'b0;
  endfunction

  // One fetch: hold inst_addr until inst_valid; optionally pulse flush in refill cycle flush_at.
  task automatic applyStimulus(input logic [31:0] a, input int flush_at);
    bit h;
    int idx, reps, expect_wait, waited;
    idx = int'((a / 16) % NL);
    h = model_hit(a);
    if (h) flush_at = 0;
    inst_addr = a;
    flush = 1'b0;
    exp_inst.push_back(mem_word(a & ~32'h3));
    model_hits++;
    expect_wait = 0;
    if (!h) begin
      reps = (flush_at > 0) ? 2 : 1;
      for (int r = 0; r < reps; r++)
        for (int w = 0; w < 4; w++) exp_bus.push_back((a & ~32'hF) + 32'(4 * w));
      model_misses += reps;
      expect_wait = reps * (4 * (wait_states + 1) + 1);
      if (flush_at > 0) model_clear();
      model_valid[idx] = 1'b1;
      model_tag[idx] = a / (16 * NL);
    end
    waited = 0;
    forever begin
      @(negedge clk);
      if (inst_valid) break;
      flush = (flush_at != 0) && (waited == flush_at);
      waited++;
      if (waited > 500) begin
        checks++;
        errors++;
        $display("[TB] FAIL fetch_timeout: addr 0x%08h got no inst_valid, expected one after %0d cycles", a, expect_wait);
        break;
      end
    end
    flush = 1'b0;
    checkOutput("miss_latency", 32'(waited), 32'(expect_wait));
    @(posedge clk);
    #1;
  endtask

  task automatic applyFlush();
    flush = 1'b1;
    if (model_hit(inst_addr)) begin
      exp_inst.push_back(mem_word(inst_addr & ~32'h3));
      model_hits++;
    end
    model_clear();
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic applyResetMidRefill(input logic [31:0] a);
    int acks, guard;
    inst_addr = a;
    for (int w = 0; w < 4; w++) exp_bus.push_back((a & ~32'hF) + 32'(4 * w));
    acks = 0;
    guard = 0;
    while (acks < 2 && guard < 200) begin
      @(negedge clk);
      if (bus.mem_req && bus.mem_ack) acks++;
      guard++;
    end
    if (acks < 2) begin
      checks++;
      errors++;
      $display("[TB] FAIL reset_refill_acks: got %0d acks, expected 2", acks);
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_req", 32'(bus.mem_req), 32'd0);
    checkOutput("async_reset_addr", bus.mem_addr, 32'd0);
    checkOutput("async_reset_valid", 32'(inst_valid), 32'd0);
    checkOutput("async_reset_inst", instruction, NOP);
    exp_bus.delete();
    exp_inst.delete();
    model_clear();
    model_hits = 0;
    model_misses = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(a, 0);
`ifdef EKA_ICACHE_PERF_EN
    checkOutput("miss_count_after_reset", miss_count, 32'd1);
    checkOutput("hit_count_after_reset", hit_count, 32'd1);
`endif
  endtask

  // Instruction memory: ack after wait_states idle cycles per word; stray acks while idle.
  initial begin
    int wcnt;
    wcnt = 0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #2;
      if (bus.mem_req) begin
        if (wcnt >= wait_states) begin
          bus.mem_ack = 1'b1;
          bus.mem_rdata = mem_word(bus.mem_addr);
          wcnt = 0;
        end else begin
          bus.mem_ack = 1'b0;
          bus.mem_rdata = $urandom;
          wcnt++;
        end
      end else begin
        wcnt = 0;
        bus.mem_ack = stray_en && ($urandom_range(0, 3) == 0);
        bus.mem_rdata = $urandom;
      end
    end
  end

  initial begin
    bit          pend;
    logic [31:0] paddr;
    pend = 1'b0;
    paddr = '0;
    forever begin
      @(negedge clk);
      if (inst_valid) begin
        checkOutput("req_while_valid", 32'(bus.mem_req), 32'd0);
        if (exp_inst.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_valid: got inst_valid=1 instruction 0x%08h, expected no output", instruction);
        end else begin
          checkOutput("instruction", instruction, exp_inst.pop_front());
        end
      end else begin
        checkOutput("nop_when_invalid", instruction, NOP);
      end
      if (pend) begin
        checkOutput("req_hold", 32'(bus.mem_req), 32'd1);
        checkOutput("addr_hold", bus.mem_addr, paddr);
      end
      if (bus.mem_req && bus.mem_ack) begin
        if (exp_bus.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_bus_read: got mem_addr 0x%08h, expected no request", bus.mem_addr);
        end else begin
          checkOutput("mem_addr", bus.mem_addr, exp_bus.pop_front());
        end
      end
      pend = bus.mem_req && !bus.mem_ack;
      paddr = bus.mem_addr;
    end
  end

  initial begin
    logic [31:0] a;
    int          fa;
    model_clear();
    #1;
    checkOutput("reset_req", 32'(bus.mem_req), 32'd0);
    checkOutput("reset_addr", bus.mem_addr, 32'd0);
    checkOutput("reset_valid", 32'(inst_valid), 32'd0);
    checkOutput("reset_inst", instruction, NOP);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    $display("[TB] directed: cold miss, hits, conflict, wait states, flush");
    applyStimulus(32'h0, 0);
    applyStimulus(32'h4, 0);
    applyStimulus(32'h8, 0);
    applyStimulus(32'hC, 0);
    applyStimulus(32'h100, 0);
    applyStimulus(32'h0, 0);
    wait_states = 3;
    applyStimulus(32'h200, 0);
    wait_states = 0;
    applyFlush();
    applyStimulus(32'h0, 0);
    applyStimulus(32'h40, 2);
    applyStimulus(32'h44, 0);
    applyFlush();
    applyResetMidRefill(32'h0);

    $display("[TB] random phase");
    stray_en = 1'b1;
    for (int n = 0; n < 300; n++) begin
      wait_states = $urandom_range(0, 2);
      if ($urandom_range(0, 9) == 0) begin
        applyFlush();
      end else begin
        a = ($urandom_range(0, 7) << 8) | $urandom_range(0, 255);
        if ($urandom_range(0, 7) == 0) a = a | ($urandom & 32'hFFFF_F800);
        fa = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 4 * (wait_states + 1)) : 0;
        applyStimulus(a, fa);
      end
    end

`ifdef EKA_ICACHE_PERF_EN
    checkOutput("hit_count", hit_count, 32'(model_hits));
    checkOutput("miss_count", miss_count, 32'(model_misses));
`endif
    reset = 1'b1;
    stray_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("exp_inst_drained", 32'(exp_inst.size()), 32'd0);
    checkOutput("exp_bus_drained", 32'(exp_bus.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
